round_ctrl: RTL and testbench

Game-round sequencer that owns the `target_gen` block. It requests each new target by pulsing `result_valid`, then times the player's shot window. It judges each shot against the current target, keeps score and a round count, and flags game over after a fixed number of rounds. It sits between the player input logic and `target_gen`, and feeds the score and display path.

---
 rtl/round_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_round_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/round_ctrl.sv
// Game-round sequencer: requests targets from target_gen, times the shot window, judges shots and keeps score.
// Optional build macro ROUND_CTRL_TOLERANCE_EN widens the hit test to a +/-1 cell neighbourhood.
module round_ctrl #(
   parameter int NUM_ROUNDS  = 8,
   parameter int ROUND_TICKS = 100,
   parameter int SCORE_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               tick,
   input  logic               fire,
   input  logic [4:0]         player_x,
   input  logic [4:0]         player_y,
   input  logic [4:0]         target_x,
   input  logic [4:0]         target_y,
   output logic               result_valid,
   output logic               round_active,
   output logic               hit,
   output logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         round_num,
   output logic [7:0]         time_left,
   output logic               game_over
);

   localparam logic [7:0]         ROUND_TICKS_C = 8'(ROUND_TICKS);
   localparam logic [3:0]         NUM_ROUNDS_C  = 4'(NUM_ROUNDS);
   localparam logic [SCORE_W-1:0] SCORE_ONE_C   = {{(SCORE_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      NEXT  = 3'd1,
      ARM   = 3'd2,
      PLAY  = 3'd3,
      JUDGE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [3:0]         round_num_q, round_num_d;
   logic [7:0]         time_left_q, time_left_d;
   logic               result_valid_q, result_valid_d;
   logic               round_active_q, round_active_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic               game_over_q, game_over_d;
   logic               shot_hit_s;
   logic [3:0]         round_inc_s;

   function automatic logic is_hit(input logic [4:0] px, input logic [4:0] py,
                                   input logic [4:0] tx, input logic [4:0] ty);
`ifdef ROUND_CTRL_TOLERANCE_EN
      logic [5:0] dx;
      logic [5:0] dy;
      // Absolute distance on the raw grid: 0 and 31 are far apart, not neighbours.
      if (px >= tx) begin
         dx = {1'b0, px} - {1'b0, tx};
      end else begin
         dx = {1'b0, tx} - {1'b0, px};
      end
      if (py >= ty) begin
         dy = {1'b0, py} - {1'b0, ty};
      end else begin
         dy = {1'b0, ty} - {1'b0, py};
      end
      return (dx <= 6'd1) && (dy <= 6'd1);
`else
      return (px == tx) && (py == ty);
`endif
   endfunction

   assign shot_hit_s  = is_hit(player_x, player_y, target_x, target_y);
   assign round_inc_s = round_num_q + 4'd1;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d        = state_q;
      score_d        = score_q;
      round_num_d    = round_num_q;
      time_left_d    = time_left_q;
      result_valid_d = 1'b0;
      round_active_d = 1'b0;
      hit_d          = 1'b0;
      miss_d         = 1'b0;
      game_over_d    = game_over_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               score_d        = '0;
               round_num_d    = 4'd0;
               time_left_d    = ROUND_TICKS_C;
               game_over_d    = 1'b0;
               result_valid_d = 1'b1;
               state_d        = NEXT;
            end else begin
               state_d = state_q;
            end
         end
         NEXT: begin
            state_d = ARM;
         end
         ARM: begin
            round_active_d = 1'b1;
            state_d        = PLAY;
         end
         PLAY: begin
            round_active_d = 1'b1;
            if (tick) begin
               time_left_d = (time_left_q > 8'd1) ? (time_left_q - 8'd1) : 8'd0;
            end else begin
               time_left_d = time_left_q;
            end
            // A shot landing on the final tick is still judged on aim.
            if (fire) begin
               hit_d          = shot_hit_s;
               miss_d         = ~shot_hit_s;
               round_active_d = 1'b0;
               state_d        = JUDGE;
            end else if (tick && (time_left_q <= 8'd1)) begin
               miss_d         = 1'b1;
               round_active_d = 1'b0;
               state_d        = JUDGE;
            end else begin
               state_d = PLAY;
            end
         end
         JUDGE: begin
            if (hit_q && !(&score_q)) begin
               score_d = score_q + SCORE_ONE_C;
            end else begin
               score_d = score_q;
            end
            round_num_d = round_inc_s;
            if (round_inc_s == NUM_ROUNDS_C) begin
               game_over_d = 1'b1;
               state_d     = DONE;
            end else begin
               result_valid_d = 1'b1;
               time_left_d    = ROUND_TICKS_C;
               state_d        = NEXT;
            end
         end
         default: begin
            game_over_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         score_q        <= '0;
         round_num_q    <= 4'd0;
         time_left_q    <= 8'd0;
         result_valid_q <= 1'b0;
         round_active_q <= 1'b0;
         hit_q          <= 1'b0;
         miss_q         <= 1'b0;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         score_q        <= score_d;
         round_num_q    <= round_num_d;
         time_left_q    <= time_left_d;
         result_valid_q <= result_valid_d;
         round_active_q <= round_active_d;
         hit_q          <= hit_d;
         miss_q         <= miss_d;
         game_over_q    <= game_over_d;
      end
   end

   assign result_valid = result_valid_q;
   assign round_active = round_active_q;
   assign hit          = hit_q;
   assign miss         = miss_q;
   assign score        = score_q;
   assign round_num    = round_num_q;
   assign time_left    = time_left_q;
   assign game_over    = game_over_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: start timing, hit, timeout, simultaneous fire/tick, full game, tolerance, mid-round reset.
module tb_round_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       tick;
   logic       fire;
   logic [4:0] player_x;
   logic [4:0] player_y;
   logic [4:0] target_x;
   logic [4:0] target_y;
   logic       result_valid;
   logic       round_active;
   logic       hit;
   logic       miss;
   logic [7:0] score;
   logic [3:0] round_num;
   logic [7:0] time_left;
   logic       game_over;

   int checks    = 0;
   int failures  = 0;
   int exp_score = 0;
   bit tol_hit;

   round_ctrl #(.NUM_ROUNDS(8), .ROUND_TICKS(100), .SCORE_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .tick         (tick),
      .fire         (fire),
      .player_x     (player_x),
      .player_y     (player_y),
      .target_x     (target_x),
      .target_y     (target_y),
      .result_valid (result_valid),
      .round_active (round_active),
      .hit          (hit),
      .miss         (miss),
      .score        (score),
      .round_num    (round_num),
      .time_left    (time_left),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Called in the NEXT cycle: walks through ARM into PLAY.
   task automatic enter_play();
      step();
      check_val("arm_rv", 32'(result_valid), 32'd0);
      check_val("arm_active", 32'(round_active), 32'd0);
      step();
      check_val("play_active", 32'(round_active), 32'd1);
      check_val("play_time", 32'(time_left), 32'd100);
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         step();
      end
      tick = 1'b0;
   endtask

   // Fires from PLAY (tick may already be set by the caller), checks the verdict and the score update.
   task automatic shot(input logic [4:0] px, input logic [4:0] py, input bit exp_hit,
                       input int exp_tl, input int rnd);
      player_x = px;
      player_y = py;
      fire     = 1'b1;
      step();
      fire = 1'b0;
      tick = 1'b0;
      check_val("judge_hit", 32'(hit), 32'(exp_hit));
      check_val("judge_miss", 32'(miss), 32'(!exp_hit));
      check_val("judge_active", 32'(round_active), 32'd0);
      check_val("judge_time", 32'(time_left), 32'(exp_tl));
      if (exp_hit) exp_score++;
      step();
      check_val("post_score", 32'(score), 32'(exp_score));
      check_val("post_round", 32'(round_num), 32'(rnd));
      check_val("post_pulse_clear", 32'({hit, miss}), 32'd0);
      if (rnd < 8) begin
         check_val("post_rv", 32'(result_valid), 32'd1);
         enter_play();
      end else begin
         check_val("post_game_over", 32'(game_over), 32'd1);
         check_val("post_rv_last", 32'(result_valid), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef ROUND_CTRL_TOLERANCE_EN
      tol_hit = 1'b1;
`else
      tol_hit = 1'b0;
`endif
      reset = 1'b1; start = 1'b0; tick = 1'b0; fire = 1'b0;
      player_x = 5'd0; player_y = 5'd0; target_x = 5'd5; target_y = 5'd7;
      repeat (5) step();
      check_val("rst_outputs", 32'({result_valid, round_active, hit, miss, game_over}), 32'd0);
      check_val("rst_counts", {score, round_num, time_left, 4'd0}, 32'd0);
      reset = 1'b0;
      step();
      check_val("idle_rv", 32'(result_valid), 32'd0);

      // Start: result_valid one cycle after, PLAY two cycles after that.
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("start_rv", 32'(result_valid), 32'd1);
      check_val("start_active", 32'(round_active), 32'd0);
      enter_play();

      // Round 1: exact hit.
      shot(5'd5, 5'd7, 1'b1, 100, 1);

      // Round 2: timeout after 100 ticks.
      run_ticks(99);
      check_val("tmo_time1", 32'(time_left), 32'd1);
      check_val("tmo_active", 32'(round_active), 32'd1);
      tick = 1'b1;
      step();
      tick = 1'b0;
      check_val("tmo_miss", 32'(miss), 32'd1);
      check_val("tmo_hit", 32'(hit), 32'd0);
      check_val("tmo_time0", 32'(time_left), 32'd0);
      step();
      check_val("tmo_score", 32'(score), 32'(exp_score));
      check_val("tmo_round", 32'(round_num), 32'd2);
      check_val("tmo_rv", 32'(result_valid), 32'd1);
      enter_play();

      // Round 3: fire with matching aim on the final tick -> hit.
      run_ticks(99);
      tick = 1'b1;
      shot(5'd5, 5'd7, 1'b1, 0, 3);

      // Round 4: aim offset (+1,-1).
      shot(5'd6, 5'd6, tol_hit, 100, 4);

      // Round 5: target (0,0), aim (31,0) -> no wrap, miss in every build.
      target_x = 5'd0; target_y = 5'd0;
      shot(5'd31, 5'd0, 1'b0, 100, 5);

      // Round 6: start ignored in PLAY, then hit.
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("start_ign_active", 32'(round_active), 32'd1);
      check_val("start_ign_rv", 32'(result_valid), 32'd0);
      target_x = 5'd20; target_y = 5'd3;
      shot(5'd20, 5'd3, 1'b1, 100, 6);

      target_x = 5'd31; target_y = 5'd31;
      shot(5'd31, 5'd31, 1'b1, 100, 7);
      target_x = 5'd0; target_y = 5'd0;
      shot(5'd0, 5'd0, 1'b1, 100, 8);
      check_val("game_score", 32'(score), tol_hit ? 32'd6 : 32'd5);

      // Fire and tick after game over have no effect.
      fire = 1'b1; tick = 1'b1;
      step();
      fire = 1'b0; tick = 1'b0;
      check_val("over_pulses", 32'({hit, miss, result_valid, round_active}), 32'd0);
      check_val("over_hold", 32'({score, round_num}), 32'({8'(exp_score), 4'd8}));
      check_val("over_flag", 32'(game_over), 32'd1);

      // Restart clears score and issues a new target request.
      start = 1'b1;
      step();
      start = 1'b0;
      exp_score = 0;
      check_val("restart_rv", 32'(result_valid), 32'd1);
      check_val("restart_clear", 32'({score, round_num, 3'd0, game_over}), 32'd0);
      enter_play();

      // Reset mid-PLAY with a pending matching shot: everything clears, no pulse.
      player_x = 5'd0; player_y = 5'd0;
      fire  = 1'b1;
      reset = 1'b1;
      #1;
      check_val("mid_rst_outputs", 32'({result_valid, round_active, hit, miss, game_over}), 32'd0);
      check_val("mid_rst_counts", {score, round_num, time_left, 4'd0}, 32'd0);
      step();
      step();
      fire  = 1'b0;
      reset = 1'b0;
      step();
      check_val("post_rst_pulses", 32'({hit, miss, result_valid, round_active}), 32'd0);
      step();
      check_val("post_rst_idle", 32'({hit, miss, result_valid, round_active, game_over}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
